sel_f2a: RTL

Write-direction router between the FTDI 32-bit synchronous FIFO port and the FPGA sinks. It accepts words written by the FTDI, parses a one-word packet header, and steers each payload word either to the TX IQ FIFO (unpacked to a 24-bit IQ pair) or to the ECPU mailbox (32 bits unchanged). It counts payload words, applies per-destination backpressure to the FTDI, and flags protocol violations.

---
 rtl/sdr_ft_pkg.sv | 27 ++
 rtl/sel_f2a_if.sv | 20 ++
 rtl/sel_f2a_iq_unpack.sv | 26 ++
 rtl/sel_f2a.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sdr_ft_pkg.sv
// ============================================================================
// Module      : sdr_ft_pkg
// Description : Widths, header fields and state encoding for the FTDI paths.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sdr_ft_pkg;

  localparam int FT_DATA_WIDTH    = 32;
  localparam int IQ_PAIR_WIDTH    = 24;
  localparam int QSTART_BIT_INDEX = 16;

  localparam int HDR_DEST_BIT = 31;
  localparam int HDR_LEN_MSB  = 15;

  localparam logic DEST_FIFO = 1'b0;
  localparam logic DEST_CPU  = 1'b1;

  typedef enum logic [0:0] {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sel_f2a_if.sv
// ============================================================================
// Module      : sel_f2a_if
// Description : FTDI write-side handshake (strobe, data, backpressure).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sel_f2a_if;
  import sdr_ft_pkg::*;

  logic                     we;
  logic [FT_DATA_WIDTH-1:0] data;
  logic                     full;

  modport master (output we, output data, input full);
  modport slave  (input we, input data, output full);

endinterface

`default_nettype wire

// File: rtl/sel_f2a_iq_unpack.sv
// ============================================================================
// Module      : iq_unpack
// Description : Combinational extract of a packed {Q, I} pair from an FTDI word.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module iq_unpack
  import sdr_ft_pkg::*;
(
  input  logic [FT_DATA_WIDTH-1:0] word_i,
  output logic [IQ_PAIR_WIDTH-1:0] iq_o
);

  localparam int HALF = IQ_PAIR_WIDTH / 2;

  assign iq_o = {word_i[QSTART_BIT_INDEX +: HALF], word_i[HALF-1:0]};

  // Padding bits around each component are discarded by design.
  logic unused_bits;
  assign unused_bits = ^{word_i[FT_DATA_WIDTH-1:QSTART_BIT_INDEX+HALF],
                         word_i[QSTART_BIT_INDEX-1:HALF]};

endmodule

`default_nettype wire

// File: rtl/sel_f2a.sv
// ============================================================================
// Module      : sel_f2a
// Description : FTDI write router: header parse, steer payload to IQ FIFO/ECPU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sel_f2a
  import sdr_ft_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_n,
  sel_f2a_if.slave                 ft,
  input  logic                     fifo_full_i,
  output logic                     fifo_we_o,
  output logic [IQ_PAIR_WIDTH-1:0] fifo_data_o,
  input  logic                     cpu_full_i,
  output logic                     cpu_we_o,
  output logic [FT_DATA_WIDTH-1:0] cpu_data_o,
  input  logic                     err_clr_i,
  output logic                     err_o,
  output logic [15:0]              drop_cnt_o
);

  state_e                   state_q, state_d;
  logic [HDR_LEN_MSB:0]     rem_q, rem_d;
  logic                     dest_q, dest_d;
  logic                     fifo_we_q, fifo_we_d;
  logic [IQ_PAIR_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic                     cpu_we_q, cpu_we_d;
  logic [FT_DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
  logic                     err_q, err_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;

  logic                     dest_full;
  logic                     drop;
  logic [IQ_PAIR_WIDTH-1:0] iq_word;

  iq_unpack u_iq_unpack (
    .word_i (ft.data),
    .iq_o   (iq_word)
  );

  assign dest_full = (dest_q == DEST_CPU) ? cpu_full_i : fifo_full_i;
  assign ft.full   = (state_q == PAYLOAD) && dest_full;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dest_d      = dest_q;
    fifo_we_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    cpu_we_d    = 1'b0;
    cpu_data_d  = cpu_data_q;
    drop        = 1'b0;

    if (ft.we) begin
      if (state_q == HDR) begin
        dest_d = ft.data[HDR_DEST_BIT];
        rem_d  = ft.data[HDR_LEN_MSB:0];
        if (ft.data[HDR_LEN_MSB:0] != '0) begin
          state_d = PAYLOAD;
        end
      end else begin
        // Dropped words still consume length so framing stays aligned.
        rem_d = rem_q - 1'b1;
        if (rem_q == 1) begin
          state_d = HDR;
        end
        if (dest_full) begin
          drop = 1'b1;
        end else if (dest_q == DEST_FIFO) begin
          fifo_we_d   = 1'b1;
          fifo_data_d = iq_word;
        end else begin
          cpu_we_d   = 1'b1;
          cpu_data_d = ft.data;
        end
      end
    end
  end

  always_comb begin
    err_d      = err_q;
    drop_cnt_d = drop_cnt_q;
    if (err_clr_i) begin
      err_d      = 1'b0;
      drop_cnt_d = '0;
    end
    // A drop coinciding with a clear counts as the first drop after it.
    if (drop) begin
      err_d = 1'b1;
      if (err_clr_i) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HDR;
      rem_q       <= '0;
      dest_q      <= DEST_FIFO;
      fifo_we_q   <= 1'b0;
      fifo_data_q <= '0;
      cpu_we_q    <= 1'b0;
      cpu_data_q  <= '0;
      err_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dest_q      <= dest_d;
      fifo_we_q   <= fifo_we_d;
      fifo_data_q <= fifo_data_d;
      cpu_we_q    <= cpu_we_d;
      cpu_data_q  <= cpu_data_d;
      err_q       <= err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fifo_we_o   = fifo_we_q;
  assign fifo_data_o = fifo_data_q;
  assign cpu_we_o    = cpu_we_q;
  assign cpu_data_o  = cpu_data_q;
  assign err_o       = err_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

`default_nettype wire
